// File: rtl/cache_refill_ctrl.sv
// Request-side controller for the 8-line cache set: latches CPU byte requests,
// sequences tag lookup, and refills a missing 32-byte line one byte per memory beat.
module cache_refill_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         req_write,
  input  logic [7:0]   req_wdata,
  output logic         resp_valid,
  output logic [7:0]   resp_data,
  output logic         stall,
  input  logic         hit,
  input  logic [255:0] line_data,
  output logic [23:0]  in_tag,
  output logic [7:0]   decOut1b,
  output logic [4:0]   offset,
  output logic [7:0]   byte_data,
  output logic         byte_we,
  output logic         fill_we,
  output logic [31:0]  decOutStall,
  output logic [7:0]   inputData,
  output logic         viv_set,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ready,
  input  logic [7:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    RESP   = 2'd3
  } stateT;

  stateT       state;
  logic [4:0]  beat;
  logic        missFlag;
  logic [23:0] tagLatch;
  logic [2:0]  indexLatch;
  logic [7:0]  decLatch;
  logic [4:0]  offsetLatch;
  logic [7:0]  dataLatch;
  logic        writeLatch;

  function automatic logic [7:0] oneHot8(input logic [2:0] sel);
    oneHot8 = 8'd1 << sel;
  endfunction

  function automatic logic [31:0] oneHot32(input logic [4:0] sel);
    oneHot32 = 32'd1 << sel;
  endfunction

  // Request latching, lookup/refill sequencing and beat counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      beat        <= 5'd0;
      missFlag    <= 1'b0;
      tagLatch    <= 24'd0;
      indexLatch  <= 3'd0;
      decLatch    <= 8'd0;
      offsetLatch <= 5'd0;
      dataLatch   <= 8'd0;
      writeLatch  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            tagLatch    <= req_addr[31:8];
            indexLatch  <= req_addr[7:5];
            decLatch    <= oneHot8(req_addr[7:5]);
            offsetLatch <= req_addr[4:0];
            dataLatch   <= req_wdata;
            writeLatch  <= req_write;
            state       <= LOOKUP;
          end else begin
            state <= IDLE;
          end
        end
        LOOKUP: begin
          if (hit) begin
            missFlag <= 1'b0;
            state    <= RESP;
          end else begin
            missFlag <= 1'b1;
            beat     <= 5'd0;
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            beat <= beat + 5'd1;
            if (beat == 5'd31) begin
              state <= RESP;
            end else begin
              state <= REFILL;
            end
          end else begin
            state <= REFILL;
          end
        end
        RESP: begin
          // Fields are cleared on the way out so an idle controller presents no stale line.
          missFlag    <= 1'b0;
          tagLatch    <= 24'd0;
          indexLatch  <= 3'd0;
          decLatch    <= 8'd0;
          offsetLatch <= 5'd0;
          dataLatch   <= 8'd0;
          writeLatch  <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state and beat; refill strobes gated by mem_ready.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_data   = 8'd0;
    stall       = 1'b0;
    byte_we     = 1'b0;
    fill_we     = 1'b0;
    decOutStall = 32'd0;
    inputData   = 8'd0;
    viv_set     = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
      end
      LOOKUP: begin
        stall = 1'b0;
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tagLatch, indexLatch, beat};
        if (mem_ready) begin
          fill_we     = 1'b1;
          decOutStall = oneHot32(beat);
          inputData   = mem_rdata;
          viv_set     = (beat == 5'd31);
        end else begin
          fill_we = 1'b0;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        stall      = missFlag;
        if (writeLatch) begin
          byte_we   = 1'b1;
          resp_data = 8'd0;
        end else begin
          resp_data = line_data[{offsetLatch, 3'b000} +: 8];
        end
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  assign in_tag    = tagLatch;
  assign decOut1b  = decLatch;
  assign offset    = offsetLatch;
  assign byte_data = dataLatch;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: hit, miss, paced refill, store, reset and hold scenarios.
module tb_cache_refill_ctrl;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_write;
  logic [7:0]   req_wdata;
  logic         resp_valid;
  logic [7:0]   resp_data;
  logic         stall;
  logic         hit;
  logic [255:0] line_data;
  logic [23:0]  in_tag;
  logic [7:0]   decOut1b;
  logic [4:0]   offset;
  logic [7:0]   byte_data;
  logic         byte_we;
  logic         fill_we;
  logic [31:0]  decOutStall;
  logic [7:0]   inputData;
  logic         viv_set;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [7:0]   mem_rdata;

  int vectors;
  int miscompares;

  // Observations gathered by do_txn
  int          latency;
  int          fillCount;
  int          vivCount;
  int          beatBad;
  int          stallCnt;
  int          readyBusy;
  logic        acceptReady;
  logic [7:0]  respData;
  logic        respWe;
  logic [4:0]  respOff;
  logic [7:0]  respByte;
  logic [23:0] respTag;
  logic [7:0]  respDec;

  cache_refill_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .stall(stall), .hit(hit),
    .line_data(line_data), .in_tag(in_tag), .decOut1b(decOut1b), .offset(offset),
    .byte_data(byte_data), .byte_we(byte_we), .fill_we(fill_we),
    .decOutStall(decOutStall), .inputData(inputData), .viv_set(viv_set),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: each byte is its low address byte xor a fixed key.
  assign mem_rdata = mem_addr[7:0] ^ 8'h3C;

  task automatic do_txn(input logic [31:0] a, input logic w, input logic [7:0] wd,
                        input logic h, input logic toggle, input logic holdV);
    int expBeat;
    logic [7:0] expByte;
    expBeat = 0; fillCount = 0; vivCount = 0; beatBad = 0; stallCnt = 0;
    readyBusy = 0; latency = 0;
    respData = 8'd0; respWe = 1'b0; respOff = 5'd0; respByte = 8'd0;
    respTag = 24'd0; respDec = 8'd0;
    req_addr = a; req_write = w; req_wdata = wd; req_valid = 1'b1; hit = h;
    mem_ready = 1'b1;
    @(negedge clk);
    acceptReady = req_ready;
    @(posedge clk); #1;
    if (!holdV) req_valid = 1'b0;
    for (int cyc = 1; cyc <= 150 && latency == 0; cyc++) begin
      @(negedge clk);
      if (stall) stallCnt++;
      if (req_ready) readyBusy++;
      if (viv_set) vivCount++;
      if (mem_req) begin
        if (mem_addr !== {a[31:5], expBeat[4:0]}) beatBad++;
        if (mem_ready) begin
          expByte = {a[7:5], expBeat[4:0]} ^ 8'h3C;
          if (fill_we !== 1'b1 || decOutStall !== (32'd1 << expBeat) ||
              inputData !== expByte || viv_set !== (expBeat == 31)) beatBad++;
          fillCount++;
          expBeat++;
        end else if (fill_we !== 1'b0 || decOutStall !== 32'd0 || viv_set !== 1'b0) begin
          beatBad++;
        end
      end else if (fill_we !== 1'b0 || viv_set !== 1'b0) begin
        beatBad++;
      end
      if (resp_valid) begin
        latency = cyc; respData = resp_data; respWe = byte_we; respOff = offset;
        respByte = byte_data; respTag = in_tag; respDec = decOut1b;
      end else if (byte_we) begin
        beatBad++;
      end
      @(posedge clk); #1;
      if (toggle) mem_ready = ~mem_ready;
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    vectors++; if ({resp_valid, stall, mem_req, fill_we, viv_set, byte_we} !== 6'b0) begin miscompares++; $display("FAIL reset_strobes: got %b want 000000", {resp_valid, stall, mem_req, fill_we, viv_set, byte_we}); end
    vectors++; if ({in_tag, decOut1b, offset, byte_data, resp_data} !== 53'd0) begin miscompares++; $display("FAIL reset_fields: got %h want 0", {in_tag, decOut1b, offset, byte_data, resp_data}); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_hit();
    line_data[7:0]  = 8'hA5;
    line_data[15:8] = 8'h5A;
    do_txn(32'h0000_0120, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++; if (acceptReady !== 1'b1) begin miscompares++; $display("FAIL hit_accept_ready: got %b want 1", acceptReady); end
    vectors++; if (latency !== 2) begin miscompares++; $display("FAIL hit_latency: got %0d want 2", latency); end
    vectors++; if (respData !== 8'hA5) begin miscompares++; $display("FAIL hit_data: got %h want a5", respData); end
    vectors++; if (stallCnt !== 0) begin miscompares++; $display("FAIL hit_stall: got %0d want 0", stallCnt); end
    vectors++; if (respDec !== 8'b0000_0010) begin miscompares++; $display("FAIL hit_dec: got %b want 00000010", respDec); end
    vectors++; if (respTag !== 24'h000001) begin miscompares++; $display("FAIL hit_tag: got %h want 000001", respTag); end
    do_txn(32'h0000_0121, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++; if (respData !== 8'h5A || respOff !== 5'd1) begin miscompares++; $display("FAIL hit_byte1: got %h/%0d want 5a/1", respData, respOff); end
  endtask

  task automatic test_read_miss();
    for (int i = 0; i < 32; i++) line_data[8*i +: 8] = 8'(i * 3 + 17);
    do_txn(32'h1234_5660, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++; if (latency !== 34) begin miscompares++; $display("FAIL miss_latency: got %0d want 34", latency); end
    vectors++; if (fillCount !== 32) begin miscompares++; $display("FAIL miss_fills: got %0d want 32", fillCount); end
    vectors++; if (beatBad !== 0) begin miscompares++; $display("FAIL miss_beats: got %0d bad beats want 0", beatBad); end
    vectors++; if (vivCount !== 1) begin miscompares++; $display("FAIL miss_viv: got %0d want 1", vivCount); end
    vectors++; if (stallCnt !== 33) begin miscompares++; $display("FAIL miss_stall: got %0d want 33", stallCnt); end
    vectors++; if (respData !== 8'h11) begin miscompares++; $display("FAIL miss_data: got %h want 11", respData); end
    vectors++; if (respTag !== 24'h123456 || respDec !== 8'b0000_1000) begin miscompares++; $display("FAIL miss_fields: got %h/%b want 123456/00001000", respTag, respDec); end
  endtask

  task automatic test_paced_refill();
    do_txn(32'h0000_0A45, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors++; if (fillCount !== 32) begin miscompares++; $display("FAIL paced_fills: got %0d want 32", fillCount); end
    vectors++; if (beatBad !== 0) begin miscompares++; $display("FAIL paced_beats: got %0d bad beats want 0", beatBad); end
    vectors++; if (latency !== 66) begin miscompares++; $display("FAIL paced_latency: got %0d want 66", latency); end
    vectors++; if (respData !== 8'h20) begin miscompares++; $display("FAIL paced_data: got %h want 20", respData); end
  endtask

  task automatic test_store_miss();
    do_txn(32'h0000_00E3, 1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
    vectors++; if (fillCount !== 32 || beatBad !== 0) begin miscompares++; $display("FAIL store_refill: got %0d fills %0d bad want 32/0", fillCount, beatBad); end
    vectors++; if (respWe !== 1'b1) begin miscompares++; $display("FAIL store_we: got %b want 1", respWe); end
    vectors++; if (respOff !== 5'd3 || respByte !== 8'h5C) begin miscompares++; $display("FAIL store_fields: got %0d/%h want 3/5c", respOff, respByte); end
    vectors++; if (respData !== 8'h00) begin miscompares++; $display("FAIL store_rdata: got %h want 00", respData); end
    vectors++; if (respDec !== 8'b1000_0000) begin miscompares++; $display("FAIL store_dec: got %b want 10000000", respDec); end
  endtask

  task automatic test_reset_mid_refill();
    int found;
    found = 0;
    req_addr = 32'h0000_0A40; req_write = 1'b0; req_wdata = 8'h00; req_valid = 1'b1;
    hit = 1'b0; mem_ready = 1'b1; vivCount = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && found == 0; cyc++) begin
      @(negedge clk);
      if (viv_set) vivCount++;
      if (mem_req && mem_addr[4:0] == 5'd10) found = 1;
    end
    vectors++; if (found !== 1) begin miscompares++; $display("FAIL rst_reach_beat10: got %0d want 1", found); end
    #1 reset = 1'b0;
    #1;
    vectors++; if ({mem_req, fill_we, viv_set, stall, resp_valid} !== 5'b0) begin miscompares++; $display("FAIL rst_async_strobes: got %b want 00000", {mem_req, fill_we, viv_set, stall, resp_valid}); end
    vectors++; if (req_ready !== 1'b1 || decOut1b !== 8'd0 || mem_addr !== 32'd0) begin miscompares++; $display("FAIL rst_async_idle: got %b/%b/%h want 1/0/0", req_ready, decOut1b, mem_addr); end
    vectors++; if (vivCount !== 0) begin miscompares++; $display("FAIL rst_viv: got %0d want 0", vivCount); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    do_txn(32'h0000_0A40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++; if (fillCount !== 32 || beatBad !== 0 || vivCount !== 1) begin miscompares++; $display("FAIL rst_restart: got %0d fills %0d bad %0d viv want 32/0/1", fillCount, beatBad, vivCount); end
  endtask

  task automatic test_hold_valid();
    do_txn(32'h0000_0200, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++; if (readyBusy !== 0) begin miscompares++; $display("FAIL hold_ready_busy: got %0d want 0", readyBusy); end
    vectors++; if (latency !== 34 || fillCount !== 32) begin miscompares++; $display("FAIL hold_single_txn: got %0d/%0d want 34/32", latency, fillCount); end
    vectors++; if (req_ready !== 1'b1 || decOut1b !== 8'd0) begin miscompares++; $display("FAIL hold_back_idle: got %b/%b want 1/0", req_ready, decOut1b); end
  endtask

  task automatic test_back_to_back();
    do_txn(32'h0000_0041, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    vectors++; if (latency !== 2 || respWe !== 1'b1 || stallCnt !== 0) begin miscompares++; $display("FAIL b2b_store_hit: got %0d/%b/%0d want 2/1/0", latency, respWe, stallCnt); end
    vectors++; if (respByte !== 8'h77 || respOff !== 5'd1 || respData !== 8'h00) begin miscompares++; $display("FAIL b2b_store_fields: got %h/%0d/%h want 77/1/00", respByte, respOff, respData); end
    do_txn(32'h0000_0042, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++; if (acceptReady !== 1'b1 || latency !== 2) begin miscompares++; $display("FAIL b2b_second_accept: got %b/%0d want 1/2", acceptReady, latency); end
    vectors++; if (respData !== 8'h17 || respWe !== 1'b0) begin miscompares++; $display("FAIL b2b_load_data: got %h/%b want 17/0", respData, respWe); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_write = 1'b0;
    req_wdata = 8'd0; hit = 1'b0; line_data = 256'd0; mem_ready = 1'b1;
    test_reset();
    test_read_hit();
    test_read_miss();
    test_paced_refill();
    test_store_miss();
    test_reset_mid_refill();
    test_hold_valid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
